// File: rtl/cam_sensor_model.sv
`default_nettype none
// ============================================================================
// Module   : cam_sensor_model
// Purpose  : Parallel camera sensor stand-in (FRAME_VALID/LINE_VALID/DATA)
//            with configurable geometry, blanking and test patterns.
// Revision : 1.0  initial release
// ============================================================================
module cam_sensor_model #(
    parameter int H_ACTIVE = 2,
    parameter int V_ACTIVE = 3,
    parameter int H_BLANK  = 1,
    parameter int V_BLANK  = 1,
    parameter int FV_LEAD  = 1,
    parameter int DATA_W   = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENABLE,
    input  logic [1:0]        PATTERN_SEL,
    input  logic [DATA_W-1:0] CONST_VAL,
    output logic              FRAME_VALID,
    output logic              LINE_VALID,
    output logic [DATA_W-1:0] DATA,
    output logic              FRAME_START,
    output logic [15:0]       FRAME_COUNT
);

    localparam int COL_W    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int ROW_W    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int CNT_MAX1 = (V_BLANK > H_BLANK) ? V_BLANK : H_BLANK;
    localparam int CNT_MAX  = (FV_LEAD > CNT_MAX1) ? FV_LEAD : CNT_MAX1;
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] C_VB_LAST   = CNT_W'(V_BLANK - 1);
    localparam logic [CNT_W-1:0] C_HB_LAST   = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] C_LEAD_LAST = CNT_W'((FV_LEAD > 0) ? FV_LEAD - 1 : 0);
    localparam logic [COL_W-1:0] C_COL_LAST  = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] C_ROW_LAST  = ROW_W'(V_ACTIVE - 1);

    localparam logic [2:0] C_IDLE   = 3'd0;
    localparam logic [2:0] C_VBLANK = 3'd1;
    localparam logic [2:0] C_LEAD   = 3'd2;
    localparam logic [2:0] C_LINE   = 3'd3;
    localparam logic [2:0] C_HBLANK = 3'd4;

    generate
        if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_BLANK < 1 || V_BLANK < 1 ||
            FV_LEAD < 0 || DATA_W < 8) begin : g_param_check
            $error("cam_sensor_model: illegal parameter set");
        end
    endgenerate

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [1:0]        pat_q, pat_d;
    logic [DATA_W-1:0] const_q, const_d;
    logic [DATA_W-1:0] ramp_q, ramp_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              fv_q, fv_d;
    logic              lv_q, lv_d;
    logic              fs_q, fs_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       fcount_q, fcount_d;

    logic              frame_start;
    logic [DATA_W-1:0] ramp_base;
    logic [7:0]        code;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        fcount_d    = fcount_q;
        frame_start = 1'b0;
        case (state_q)
            C_IDLE: begin
                if (ENABLE) begin
                    state_d = C_VBLANK;
                    cnt_d   = '0;
                end
            end
            C_VBLANK: begin
                if (cnt_q == C_VB_LAST) begin
                    frame_start = 1'b1;
                    row_d       = '0;
                    col_d       = '0;
                    cnt_d       = '0;
                    state_d     = (FV_LEAD > 0) ? C_LEAD : C_LINE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            C_LEAD: begin
                if (cnt_q == C_LEAD_LAST) begin
                    state_d = C_LINE;
                    col_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            C_LINE: begin
                if (col_q == C_COL_LAST) begin
                    cnt_d = '0;
                    // Last pixel of the last line: frame closes, ENABLE decides what follows
                    if (row_q == C_ROW_LAST) begin
                        fcount_d = fcount_q + 16'd1;
                        state_d  = ENABLE ? C_VBLANK : C_IDLE;
                    end else begin
                        state_d = C_HBLANK;
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            C_HBLANK: begin
                if (cnt_q == C_HB_LAST) begin
                    state_d = C_LINE;
                    col_d   = '0;
                    row_d   = row_q + ROW_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        pat_d     = frame_start ? PATTERN_SEL : pat_q;
        const_d   = frame_start ? CONST_VAL : const_q;
        ramp_base = frame_start ? '0 : ramp_q;
        ramp_d    = ramp_base;
        lfsr_d    = lfsr_q;
        data_d    = '0;
        code      = 8'((int'(row_d) + 1) * 10 + int'(col_d) + 1);
        fv_d      = (state_d == C_LEAD) || (state_d == C_LINE) || (state_d == C_HBLANK);
        lv_d      = (state_d == C_LINE);
        fs_d      = frame_start;
        if (state_d == C_LINE) begin
            ramp_d = ramp_base + DATA_W'(1);
            // LFSR only steps on pixels that actually show it
            if (pat_d == 2'd3) begin
                lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            end
            case (pat_d)
                2'd0:    data_d = DATA_W'(code) << (DATA_W - 8);
                2'd1:    data_d = ramp_base;
                2'd2:    data_d = const_d;
                default: data_d = DATA_W'(lfsr_d);
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= C_IDLE;
            cnt_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            pat_q    <= '0;
            const_q  <= '0;
            ramp_q   <= '0;
            lfsr_q   <= 16'h0001;
            fv_q     <= 1'b0;
            lv_q     <= 1'b0;
            fs_q     <= 1'b0;
            data_q   <= '0;
            fcount_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            row_q    <= row_d;
            pat_q    <= pat_d;
            const_q  <= const_d;
            ramp_q   <= ramp_d;
            lfsr_q   <= lfsr_d;
            fv_q     <= fv_d;
            lv_q     <= lv_d;
            fs_q     <= fs_d;
            data_q   <= data_d;
            fcount_q <= fcount_d;
        end
    end

    assign FRAME_VALID = fv_q;
    assign LINE_VALID  = lv_q;
    assign DATA        = data_q;
    assign FRAME_START = fs_q;
    assign FRAME_COUNT = fcount_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_sensor_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_sensor_model
// Purpose  : Self-checking bench for cam_sensor_model (frame-level model plus
//            directed literal checks and a second, larger-geometry instance).
// Revision : 1.0  initial release
// ============================================================================
module tb_cam_sensor_model;

    localparam int H_A = 2, V_A = 3, H_B = 1, V_B = 1, LEAD = 1;
    localparam int H2 = 20, V2 = 26;

    typedef struct packed {
        logic       fv;
        logic       lv;
        logic       fs;
        logic [9:0] data;
    } cyc_t;

    logic       clk, rst, en;
    logic [1:0] pat;
    logic [9:0] cval;
    logic       fv, lv, fs;
    logic [9:0] data;
    logic [15:0] fcnt;

    logic       rst2, en2;
    logic [1:0] pat2;
    logic [7:0] cval2;
    logic       fv2, lv2, fs2;
    logic [7:0] data2;
    logic [15:0] fcnt2;

    int n_tests = 0;
    int n_fail  = 0;

    cam_sensor_model u_dut (
        .CLK(clk), .RST(rst), .ENABLE(en), .PATTERN_SEL(pat), .CONST_VAL(cval),
        .FRAME_VALID(fv), .LINE_VALID(lv), .DATA(data), .FRAME_START(fs), .FRAME_COUNT(fcnt)
    );

    cam_sensor_model #(
        .H_ACTIVE(H2), .V_ACTIVE(V2), .H_BLANK(3), .V_BLANK(2), .FV_LEAD(0), .DATA_W(8)
    ) u_dut2 (
        .CLK(clk), .RST(rst2), .ENABLE(en2), .PATTERN_SEL(pat2), .CONST_VAL(cval2),
        .FRAME_VALID(fv2), .LINE_VALID(lv2), .DATA(data2), .FRAME_START(fs2), .FRAME_COUNT(fcnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    cyc_t        exp_q[$];
    cyc_t        cur;
    logic [15:0] m_lfsr;
    int          m_count;
    bit          m_pending, m_inframe;

    function automatic cyc_t mk(input logic f, input logic l, input logic s, input logic [9:0] d);
        cyc_t c;
        c.fv = f; c.lv = l; c.fs = s; c.data = d;
        return c;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            cur       = '0;
            m_lfsr    = 16'h0001;
            m_count   = 0;
            m_pending = 0;
            m_inframe = 0;
        end else begin
            if (exp_q.size() == 0) begin
                if (m_pending) begin
                    logic [1:0] p;
                    logic [9:0] cv;
                    logic [9:0] px;
                    int k;
                    p = pat; cv = cval; k = 0;
                    m_pending = 0;
                    m_inframe = 1;
                    for (int i = 0; i < LEAD; i++) exp_q.push_back(mk(1, 0, i == 0, 10'd0));
                    for (int r = 0; r < V_A; r++) begin
                        for (int c = 0; c < H_A; c++) begin
                            case (p)
                                2'd0: px = 10'((((r + 1) * 10 + c + 1) % 256) * 4);
                                2'd1: px = 10'(k);
                                2'd2: px = cv;
                                default: begin m_lfsr = lfsr_step(m_lfsr); px = m_lfsr[9:0]; end
                            endcase
                            exp_q.push_back(mk(1, 1, (LEAD == 0) && (k == 0), px));
                            k++;
                        end
                        if (r < V_A - 1)
                            for (int h = 0; h < H_B; h++) exp_q.push_back(mk(1, 0, 0, 10'd0));
                    end
                end else begin
                    if (m_inframe) begin
                        m_count   = (m_count + 1) % 65536;
                        m_inframe = 0;
                    end
                    if (en) begin
                        for (int v = 0; v < V_B; v++) exp_q.push_back(mk(0, 0, 0, 10'd0));
                        m_pending = 1;
                    end
                end
            end
            cur = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        end
    end

    always @(negedge clk) begin
        n_tests++;
        if ({fv, lv, fs, data} !== {cur.fv, cur.lv, cur.fs, cur.data}) begin
            n_fail++;
            $display("FAIL model_outputs t=%0t: got fv=%b lv=%b fs=%b data=%h, expected fv=%b lv=%b fs=%b data=%h",
                     $time, fv, lv, fs, data, cur.fv, cur.lv, cur.fs, cur.data);
        end
        n_tests++;
        if (fcnt !== 16'(m_count)) begin
            n_fail++;
            $display("FAIL model_count t=%0t: got %0d, expected %0d", $time, fcnt, m_count);
        end
    end

    // ---------------- large-geometry instance checker ----------------
    int k2 = 0, frames2 = 0;
    bit prev2 = 0;
    always @(negedge clk) begin
        if (rst2) begin
            k2 = 0; prev2 = 0;
        end else begin
            if (fv2 && !prev2) begin
                n_tests++;
                if (!(lv2 && fs2)) begin
                    n_fail++;
                    $display("FAIL inst2_rise: got lv=%b fs=%b, expected lv=1 fs=1", lv2, fs2);
                end
            end
            if (lv2) begin
                logic [7:0] e2;
                e2 = 8'(((k2 / H2) + 1) * 10 + (k2 % H2) + 1);
                n_tests++;
                if (data2 !== e2) begin
                    n_fail++;
                    $display("FAIL inst2_data px=%0d: got %0d, expected %0d", k2, data2, e2);
                end
                k2++;
            end
            if (!fv2 && prev2) begin
                chk("inst2_lv_cycles", k2, H2 * V2);
                k2 = 0;
                frames2++;
            end
            prev2 = fv2;
        end
    end

    // ---------------- directed + random stimulus ----------------
    int px[$];
    int fs_seen;

    task automatic grab_frame(input int mid_px, input int action);
        int guard;
        px.delete();
        fs_seen = 0;
        guard = 0;
        while (!fv && guard < 100) begin @(negedge clk); guard++; end
        if (!fv) begin chk("frame_start_timeout", 0, 1); return; end
        guard = 0;
        while (fv && guard < 200) begin
            if (fs) fs_seen++;
            if (lv) begin
                px.push_back(int'(data));
                if (px.size() == mid_px) begin
                    if (action == 1) en = 1'b0;
                    if (action == 2) pat = 2'd3;
                    if (action == 3) begin
                        #2 rst = 1'b1;
                        #1;
                        chk("async_rst_fv", int'(fv), 0);
                        chk("async_rst_lv", int'(lv), 0);
                        chk("async_rst_data", int'(data), 0);
                        chk("async_rst_count", int'(fcnt), 0);
                        @(negedge clk);
                        rst = 1'b0;
                        return;
                    end
                end
            end
            @(negedge clk);
            guard++;
        end
        if (fv) chk("frame_end_timeout", 0, 1);
    endtask

    task automatic latency_check(input string name);
        int n;
        n = 0;
        en = 1'b1;
        while (!fv && n < 20) begin @(negedge clk); n++; end
        chk(name, n, V_B + 1);
    endtask

    initial begin
        int lit0[6];
        int idle_fv;
        lit0 = '{44, 48, 84, 88, 124, 128};
        rst = 1'b1; en = 1'b0; pat = 2'd0; cval = 10'd0;
        rst2 = 1'b1; en2 = 1'b1; pat2 = 2'd0; cval2 = 8'd0;
        repeat (5) @(negedge clk);
        chk("reset_fv", int'(fv), 0);
        chk("reset_data", int'(data), 0);
        chk("reset_count", int'(fcnt), 0);
        rst = 1'b0; rst2 = 1'b0;

        // pattern 0 literal frame
        latency_check("fv_latency");
        grab_frame(0, 0);
        chk("p0_npix", px.size(), 6);
        for (int i = 0; i < 6 && i < px.size(); i++) chk($sformatf("p0_px%0d", i), px[i], lit0[i]);
        chk("p0_fs_pulses", fs_seen, 1);

        // ramp across three frames after a fresh reset
        rst = 1'b1; @(negedge clk); pat = 2'd1; rst = 1'b0;
        for (int f = 1; f <= 3; f++) begin
            grab_frame(0, 0);
            chk("ramp_npix", px.size(), 6);
            for (int i = 0; i < px.size(); i++) chk($sformatf("ramp_f%0d_px%0d", f, i), px[i], i);
            chk($sformatf("ramp_count_f%0d", f), int'(fcnt), f);
        end

        // ENABLE dropped mid-frame: frame completes, then idle
        grab_frame(3, 1);
        chk("endrop_npix", px.size(), 6);
        idle_fv = 0;
        repeat (8) begin @(negedge clk); if (fv) idle_fv++; end
        chk("endrop_idle_fv", idle_fv, 0);
        latency_check("fv_latency_restart");

        // reset pulsed during line 1, then clean restart
        pat = 2'd0;
        grab_frame(3, 3);
        grab_frame(0, 0);
        chk("post_rst_npix", px.size(), 6);
        if (px.size() > 0) chk("post_rst_px0", px[0], 44);
        chk("post_rst_count", int'(fcnt), 1);

        // pattern 2 -> 3 mid-frame
        pat = 2'd2; cval = 10'h155;
        grab_frame(2, 2);
        for (int i = 0; i < px.size(); i++) chk($sformatf("const_px%0d", i), px[i], 'h155);
        grab_frame(0, 0);
        if (px.size() >= 2) begin
            chk("lfsr_px0", px[0], 'h002);
            chk("lfsr_px1", px[1], 'h004);
        end else chk("lfsr_npix", px.size(), 6);

        // randomized phase, checked by the model every cycle
        for (int i = 0; i < 1500; i++) begin
            int r;
            @(negedge clk);
            r = int'($urandom_range(0, 199));
            rst = (r == 199);
            if (r < 4) en = ~en;
            if (r < 20) pat = 2'($urandom);
            if (r < 30) cval = 10'($urandom);
        end
        rst = 1'b0; en = 1'b1;

        for (int g = 0; g < 3000 && frames2 < 2; g++) @(negedge clk);
        chk("inst2_frames_seen", int'(frames2 >= 2), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cam_sensor_model.md
Name: cam_sensor_model

Overview:
- Synthesizable, parametrised model of the parallel camera sensor interface (FRAME_VALID / LINE_VALID / DATA).
- Generates configurable frame geometry, blanking and test patterns, so the capture path and the UART readout can be exercised both in benches and on hardware without a real sensor.
- Sits in place of the sensor pins and drives the capture block's CAM_* inputs.

Parameters:
H_ACTIVE, 2, active pixels per line (>=1)
V_ACTIVE, 3, active lines per frame (>=1)
H_BLANK, 1, LINE_VALID-low cycles between lines (>=1)
V_BLANK, 1, cycles with FRAME_VALID low between frames (>=1)
FV_LEAD, 1, cycles with FRAME_VALID high before the first line (>=0)
DATA_W, 10, pixel width (>=8)

Ports:
CLK  input  1  pixel clock; all logic on the rising edge
RST  input  1  asynchronous, active-high reset
ENABLE  input  1  frame generation enable
PATTERN_SEL  input  2  pattern: 0 row/col code, 1 ramp, 2 constant, 3 LFSR
CONST_VAL  input  DATA_W  pixel value for pattern 2
FRAME_VALID  output  1  frame active
LINE_VALID  output  1  line active; pixel qualifier
DATA  output  DATA_W  pixel data, valid only while LINE_VALID=1
FRAME_START  output  1  one-cycle pulse in the first FRAME_VALID-high cycle
FRAME_COUNT  output  16  number of completed frames, wraps at 65535->0

Behaviour:
- Reset: all outputs 0. The FSM enters IDLE, the LFSR loads 1 and the counters clear. Reset asserted mid-frame drops FRAME_VALID and LINE_VALID asynchronously. No partial frame resumes after reset.
- FSM states:
  - IDLE: FRAME_VALID=0, LINE_VALID=0. Moves to VBLANK when ENABLE=1.
  - VBLANK: lasts V_BLANK cycles, with FRAME_VALID=0. Then goes to LEAD, or straight to LINE if FV_LEAD=0.
  - LEAD: lasts FV_LEAD cycles, with FRAME_VALID=1 and LINE_VALID=0.
  - LINE: lasts H_ACTIVE cycles, with FRAME_VALID=1 and LINE_VALID=1.
  - HBLANK: lasts H_BLANK cycles, with FRAME_VALID=1 and LINE_VALID=0. Entered only between lines, never after the last line.
  - Frame end: after the last pixel of line V_ACTIVE-1, FRAME_VALID and LINE_VALID fall together on the next edge. FRAME_COUNT increments in that same cycle. The FSM then goes to VBLANK if ENABLE=1, otherwise to IDLE.
- Outputs are registered and driven directly from the state/counters. Latency from ENABLE rising to FRAME_VALID rising is V_BLANK+1 cycles.
- ENABLE deassertion is frame-atomic. A frame in progress always completes. ENABLE is sampled only in IDLE and at frame end.
- PATTERN_SEL and CONST_VAL are latched at frame start. Changes mid-frame have no effect until the next frame.
- Row and column counters: col 0..H_ACTIVE-1 and row 0..V_ACTIVE-1, each with width clog2 of its range (minimum 1).
- Patterns (shown values are DATA):
  - 0: code = ((row+1)*10 + (col+1)) mod 256, left-shifted by DATA_W-8 with low bits 0. For example row 0, col 1 with DATA_W=10 gives 12<<2 = 48.
  - 1: ramp counter of DATA_W bits, reset to 0 at frame start, incrementing per pixel and wrapping at 2^DATA_W.
  - 2: CONST_VAL on every pixel.
  - 3: 16-bit Fibonacci LFSR with taps 16,14,13,11, advanced once per pixel and never reset between frames. DATA is the low DATA_W bits, or zero-extended if DATA_W>16.
- DATA is held at 0 whenever LINE_VALID=0.
- FRAME_START is high exactly one cycle per frame, in the cycle FRAME_VALID first rises.
- Parameter violations (any >=1 bound broken, DATA_W<8) are a compile-time error via a generate-time check.

Test Plan:
- Defaults, RST=1 for 5 cycles then released, ENABLE=1, PATTERN_SEL=0 -> FRAME_VALID rises 2 cycles after ENABLE; per frame the sequence is LEAD 1 cycle, then DATA=44,48 / gap / 84,88 / gap / 124,128, with LINE_VALID high 2 cycles per line; FRAME_VALID low 1 cycle between frames; 1 FRAME_START pulse per frame.
- PATTERN_SEL=1 across 3 frames -> DATA is 0..5 in each frame; FRAME_COUNT reads 1,2,3 at the respective frame ends.
- ENABLE dropped after the 3rd pixel of a frame -> that frame completes fully (6 pixels), then the model sits in IDLE with FRAME_VALID=0; re-assert restarts after V_BLANK+1 cycles.
- RST pulsed during line 1 -> FRAME_VALID, LINE_VALID and DATA are 0 before the next edge; FRAME_COUNT=0; the next frame starts clean from row 0, col 0.
- PATTERN_SEL changed 2->3 mid-frame with CONST_VAL=0x155 -> the current frame stays all 0x155; the next frame carries LFSR values starting 0x002,0x004 (low 10 bits).
- H_ACTIVE=640, V_ACTIVE=480, FV_LEAD=0 -> exactly 307200 LINE_VALID-high cycles per frame; LINE_VALID rises with FRAME_VALID; the pattern-0 code wraps mod 256.
